// File: rtl/shift_exec_pipe.sv
// Two-stage pipelined shift execute unit (SRL/SLL/SRA/ROR) with valid/ready on both sides.
// Optional counters stat_ops/stat_stall are built when SHIFT_EXEC_STATS_EN is defined.
module shift_exec_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SH_W  = 6,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SH_W-1:0]  in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
`ifdef SHIFT_EXEC_STATS_EN
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_stall,
`endif
  output logic             out_zero
);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic             r_s1_valid;
  logic [1:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [SH_W-1:0]  r_s1_shamt;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_tag;
  logic             r_zero;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;
  logic [WIDTH-1:0] w_shift;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = r_s1_valid && w_s2_adv;
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && in_ready;

  // Log-stage barrel network: level k moves the operand by 2^k when shamt[k] is set.
  always_comb begin
    w_shift = r_s1_a;
    for (int k = 0; k < int'(SH_W); k++) begin
      if (r_s1_shamt[k]) begin
        case (r_s1_op)
          OP_SRL:  w_shift = w_shift >> (32'(1) << k);
          OP_SLL:  w_shift = w_shift << (32'(1) << k);
          OP_SRA:  w_shift = WIDTH'($signed(w_shift) >>> (32'(1) << k));
          OP_ROR:  w_shift = (w_shift >> (32'(1) << k)) |
                             (w_shift << (WIDTH - (32'(1) << k)));
          default: w_shift = r_s1_a;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_shamt <= '0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_tag      <= '0;
      r_zero     <= 1'b0;
    end else begin
      r_s1_valid <= w_accept || (r_s1_valid && !w_s2_adv);
      r_s2_valid <= w_s1_adv || (r_s2_valid && !out_ready);
      if (w_accept) begin
        r_s1_op    <= in_op;
        r_s1_a     <= in_a;
        r_s1_shamt <= in_shamt;
        r_s1_tag   <= in_tag;
      end
      if (w_s1_adv) begin
        r_result <= w_shift;
        r_tag    <= r_s1_tag;
        r_zero   <= (w_shift == '0);
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_result;
  assign out_tag    = r_tag;
  assign out_zero   = r_zero;

`ifdef SHIFT_EXEC_STATS_EN
  logic [31:0] r_stat_ops;
  logic [31:0] r_stat_stall;

  // Delivered results and writeback-stall cycles, both free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_ops   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (r_s2_valid && out_ready)  r_stat_ops   <= r_stat_ops + 32'd1;
      if (r_s2_valid && !out_ready) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_ops   = r_stat_ops;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Directed self-checking bench for shift_exec_pipe: ops, latency, backpressure, reset mid-flight.
module tb_shift_exec_pipe;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned SH_W  = 6;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [SH_W-1:0]  in_shamt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
`ifdef SHIFT_EXEC_STATS_EN
  logic [31:0]      stat_ops;
  logic [31:0]      stat_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shift_exec_pipe #(.WIDTH(WIDTH), .SH_W(SH_W), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
`ifdef SHIFT_EXEC_STATS_EN
    .stat_ops   (stat_ops),
    .stat_stall (stat_stall),
`endif
    .out_zero   (out_zero)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [63:0] a,
                        input logic [5:0] sh, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_shamt = sh;
    in_tag   = tag;
  endtask

  // Single op with out_ready high: accepted on one edge, out_valid two edges later.
  task automatic run_op(input string name, input logic [1:0] op, input logic [63:0] a,
                        input logic [5:0] sh, input logic [4:0] tag,
                        input logic [63:0] exp_res, input logic exp_zero);
    out_ready = 1'b1;
    set_op(op, a, sh, tag);
    #1;
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check({name, "_lat1_valid"}, 64'(out_valid), 64'd0);
    tick();
    check({name, "_lat2_valid"}, 64'(out_valid), 64'd1);
    check({name, "_result"}, out_result, exp_res);
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    check({name, "_zero"}, 64'(out_zero), 64'(exp_zero));
    tick();
  endtask

  logic [63:0] bp_exp [6] = '{64'h1, 64'h20, 64'h400, 64'h8000, 64'h10_0000, 64'h200_0000};
  logic [5:0]  bp_sh  [6] = '{6'd0, 6'd5, 6'd10, 6'd15, 6'd20, 6'd25};

  initial begin
    int          sent;
    int          recv;
    bit          dropped;
    bit          was_stall;
    bit          leaked;
    logic [63:0] hold_r;
    logic [4:0]  hold_t;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_shamt  = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run_op("srl63", 2'b00, 64'h8000_0000_0000_0000, 6'd63, 5'd3, 64'h1, 1'b0);
    run_op("sra4",  2'b10, 64'hF000_0000_0000_00F1, 6'd4, 5'd4, 64'hFF00_0000_0000_000F, 1'b0);
    run_op("ror4",  2'b11, 64'hF000_0000_0000_00F1, 6'd4, 5'd5, 64'h1F00_0000_0000_000F, 1'b0);
    run_op("sll8",  2'b01, 64'hF000_0000_0000_00F1, 6'd8, 5'd6, 64'h0000_0000_0000_F100, 1'b0);
    run_op("srl_zero", 2'b00, 64'hFF, 6'd8, 5'd7, 64'h0, 1'b1);
    run_op("ror_id", 2'b11, 64'h0123_4567_89AB_CDEF, 6'd0, 5'd8, 64'h0123_4567_89AB_CDEF, 1'b0);
    run_op("sra_id", 2'b10, 64'h8123_4567_89AB_CDEF, 6'd0, 5'd9, 64'h8123_4567_89AB_CDEF, 1'b0);
    run_op("sra63", 2'b10, 64'h8000_0000_0000_0000, 6'd63, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("sra63_pos", 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 6'd63, 5'd11, 64'h0, 1'b1);
    run_op("sll63", 2'b01, 64'h3, 6'd63, 5'd12, 64'h8000_0000_0000_0000, 1'b0);
    run_op("ror63", 2'b11, 64'h8000_0000_0000_0001, 6'd63, 5'd13, 64'h3, 1'b0);

    // Back-to-back stream of six SLLs with writeback stalled in cycles 3..7.
    sent = 0; recv = 0; dropped = 0; was_stall = 0; hold_r = '0; hold_t = '0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      if (sent < 6) set_op(2'b01, 64'h1, bp_sh[sent], 5'(sent + 10));
      else in_valid = 1'b0;
      #1;
      if (was_stall) begin
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_result", out_result, hold_r);
        check("bp_hold_tag", 64'(out_tag), 64'(hold_t));
      end
      if (in_valid && !in_ready) dropped = 1'b1;
      if (out_valid && out_ready) begin
        if (recv < 6) begin
          check("bp_result", out_result, bp_exp[recv]);
          check("bp_tag", 64'(out_tag), 64'(recv + 10));
        end else begin
          check("bp_duplicate", 64'(recv), 64'd5);
        end
        recv++;
      end
      was_stall = out_valid && !out_ready;
      hold_r    = out_result;
      hold_t    = out_tag;
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_in_ready_dropped", 64'(dropped), 64'd1);
    check("bp_sent", 64'(sent), 64'd6);
    check("bp_received", 64'(recv), 64'd6);
    check("bp_in_ready_after", 64'(in_ready), 64'd1);

    // Two ops in flight with writeback held off, then a one-cycle reset.
    out_ready = 1'b0;
    leaked = 0;
    set_op(2'b00, 64'hAAAA, 6'd1, 5'd20);
    tick();
    set_op(2'b00, 64'hBBBB, 6'd1, 5'd21);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 5; c++) begin
      if (out_valid) leaked = 1'b1;
      tick();
    end
    check("rstmid_no_result", 64'(leaked), 64'd0);

`ifdef SHIFT_EXEC_STATS_EN
    // Four results delivered with exactly three stall cycles after a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("stat_rst_ops", 64'(stat_ops), 64'd0);
    check("stat_rst_stall", 64'(stat_stall), 64'd0);
    sent = 0; recv = 0;
    begin
      int stalls;
      stalls = 0;
      for (int c = 0; c < 30; c++) begin
        out_ready = (stalls >= 3);
        if (sent < 4) set_op(2'b01, 64'h1, 6'd1, 5'(sent));
        else in_valid = 1'b0;
        #1;
        if (out_valid && !out_ready) stalls++;
        if (out_valid && out_ready) recv++;
        if (in_valid && in_ready) sent++;
        tick();
      end
    end
    in_valid = 1'b0;
    check("stat_ops", 64'(stat_ops), 64'd4);
    check("stat_stall", 64'(stat_stall), 64'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
